// File: rtl/cmos_dvp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : cmos_dvp_tx
//  Purpose  : OV5640-style DVP camera-side transmitter. Converts an upstream
//             RGB888 ready/valid pixel stream into cam_vsync / cam_href /
//             8-bit cam_data, two RGB565 bytes per pixel, high byte first.
//  Ports    : cam_pclk     - pixel clock, all logic on the rising edge
//             rst_n        - synchronous active-low reset
//             tx_en        - enable, sampled only at frame boundaries
//             pattern_sel  - (CMOS_DVP_TX_TEST_PATTERN_EN only) colour bars
//             pix_data     - RGB888 {R,G,B}
//             pix_valid    - pix_data valid
//             pix_ready    - pixel accepted when pix_valid && pix_ready
//             cam_vsync    - frame sync, active high (registered)
//             cam_href     - line valid, active high (registered)
//             cam_data     - DVP byte (registered)
//             frame_done   - pulse on the last cycle of the frame
//             underrun     - sticky: a pixel slot passed with no valid data
//             frame_cnt    - completed frames, wrapping
//  Options  : `define CMOS_DVP_TX_TEST_PATTERN_EN adds the pattern_sel input
//             and an internal 8-bar colour pattern source.
//  Revision : 1.0 - initial release
// ============================================================================
module cmos_dvp_tx #(
    parameter int H_ACT     = 640,
    parameter int H_BLANK   = 160,
    parameter int V_ACT     = 480,
    parameter int VSYNC_LEN = 4,
    parameter int V_BP      = 8,
    parameter int V_FP      = 8
) (
    input  logic        cam_pclk,
    input  logic        rst_n,
    input  logic        tx_en,
`ifdef CMOS_DVP_TX_TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam int          LINE_LEN     = 2 * H_ACT + H_BLANK;
    localparam logic [11:0] C_LINE_LAST  = 12'(LINE_LEN - 1);
    localparam logic [11:0] C_ACT_BYTES  = 12'(2 * H_ACT);
    localparam logic [10:0] C_VSYNC_LAST = 11'(VSYNC_LEN - 1);
    localparam logic [10:0] C_VBP_LAST   = 11'(V_BP - 1);
    localparam logic [10:0] C_VACT_LAST  = 11'(V_ACT - 1);
    localparam logic [10:0] C_VFP_LAST   = 11'(V_FP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBP    = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFP    = 3'd4
    } state_t;

    // First state of a frame, skipping zero-length blanking sections.
    function automatic state_t first_state();
        if (VSYNC_LEN > 0)  return S_VSYNC;
        else if (V_BP > 0)  return S_VBP;
        else                return S_ACTIVE;
    endfunction

    state_t      state_q, state_d;
    logic [11:0] hcnt_q;
    logic [10:0] vcnt_q;
    logic        vsync_q, href_q, underrun_q;
    logic [7:0]  data_q, low_q;
    logic [15:0] frame_cnt_q;

    logic        w_line_end, w_sec_last, w_sec_end, w_frame_end;
    logic        w_in_act, w_slot, w_pat, w_pix_ok;
    logic [23:0] w_src;
    logic [7:0]  w_hi, w_lo;
    state_t      w_restart;

    assign w_line_end = (hcnt_q == C_LINE_LAST);

    always_comb begin
        w_sec_last = 1'b0;
        case (state_q)
            S_VSYNC:  w_sec_last = (vcnt_q == C_VSYNC_LAST);
            S_VBP:    w_sec_last = (vcnt_q == C_VBP_LAST);
            S_ACTIVE: w_sec_last = (vcnt_q == C_VACT_LAST);
            S_VFP:    w_sec_last = (vcnt_q == C_VFP_LAST);
            default:  w_sec_last = 1'b0;
        endcase
    end

    assign w_sec_end = w_line_end && w_sec_last;

    // With no front porch the frame ends on the last active cycle.
    assign w_frame_end = (V_FP > 0) ? (state_q == S_VFP    && w_sec_end)
                                    : (state_q == S_ACTIVE && w_sec_end);

    assign w_restart = tx_en ? first_state() : S_IDLE;

    // State entered when the current section finishes its last line.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_VSYNC:  state_d = (V_BP > 0) ? S_VBP : S_ACTIVE;
            S_VBP:    state_d = S_ACTIVE;
            S_ACTIVE: state_d = (V_FP > 0) ? S_VFP : w_restart;
            S_VFP:    state_d = w_restart;
            default:  state_d = S_IDLE;
        endcase
    end

    assign w_in_act = (state_q == S_ACTIVE) && (hcnt_q < C_ACT_BYTES);
    assign w_slot   = w_in_act && !hcnt_q[0];

`ifdef CMOS_DVP_TX_TEST_PATTERN_EN
    logic        pat_q;
    logic [15:0] w_x8;
    logic [2:0]  w_bar;
    logic        w_frame_start;

    assign w_frame_start = tx_en && ((state_q == S_IDLE) || w_frame_end);

    always_ff @(posedge cam_pclk) begin
        if (!rst_n)
            pat_q <= 1'b0;
        else if (w_frame_start)
            pat_q <= pattern_sel;
    end

    // On even hcnt the pixel index is hcnt/2, so pixel_x*8 == hcnt*4.
    // Bar index = number of bar boundaries (k*H_ACT) already passed.
    assign w_x8 = {2'b00, hcnt_q, 2'b00};

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_x8 >= 16'(k * H_ACT))
                w_bar = w_bar + 3'd1;
        end
    end

    // white, yellow, cyan, green, magenta, red, blue, black
    assign w_pat = pat_q;
    assign w_src = w_pat ? {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}}
                         : pix_data;
`else
    assign w_pat = 1'b0;
    assign w_src = pix_data;
`endif

    assign w_pix_ok  = w_pat || pix_valid;
    assign w_hi      = {w_src[23:19], w_src[15:13]};
    assign w_lo      = {w_src[12:10], w_src[7:3]};

    // Channel LSBs dropped by RGB565 truncation.
    logic w_unused_bits;
    assign w_unused_bits = ^{w_src[18:16], w_src[9:8], w_src[2:0]};

    assign pix_ready = w_slot && !w_pat;

    always_ff @(posedge cam_pclk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= '0;
            low_q       <= '0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (state_q == S_IDLE) begin
                hcnt_q <= '0;
                vcnt_q <= '0;
                if (tx_en)
                    state_q <= first_state();
            end else if (w_line_end) begin
                hcnt_q <= '0;
                vcnt_q <= w_sec_last ? 11'd0 : vcnt_q + 11'd1;
                if (w_sec_last)
                    state_q <= state_d;
            end else begin
                hcnt_q <= hcnt_q + 12'd1;
            end

            if (w_frame_end)
                frame_cnt_q <= frame_cnt_q + 16'd1;

            vsync_q <= (state_q == S_VSYNC);
            href_q  <= w_in_act;

            // High byte goes out now; low byte is parked for the odd slot.
            // A missing pixel is sent as two zero bytes.
            if (w_slot) begin
                data_q <= w_pix_ok ? w_hi : 8'h00;
                low_q  <= w_pix_ok ? w_lo : 8'h00;
            end else if (w_in_act) begin
                data_q <= low_q;
            end else begin
                data_q <= 8'h00;
            end

            if (pix_ready && !pix_valid)
                underrun_q <= 1'b1;
        end
    end

    assign cam_vsync  = vsync_q;
    assign cam_href   = href_q;
    assign cam_data   = data_q;
    assign frame_done = w_frame_end;
    assign underrun   = underrun_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cmos_dvp_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmos_dvp_tx
//  Purpose  : Self-checking bench for cmos_dvp_tx with a small raster
//             (H_ACT=4, H_BLANK=6, V_ACT=3, VSYNC_LEN=1, V_BP=1, V_FP=1;
//             14-cycle lines, 84-cycle frames). Cycle c=0 is the first cycle
//             the transmitter sits in VSYNC; outputs are sampled 1 ns after
//             each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmos_dvp_tx;

    logic        cam_pclk = 1'b0;
    logic        rst_n;
    logic        tx_en;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_done;
    logic        underrun;
    logic [15:0] frame_cnt;

    int checks = 0;
    int passed = 0;

    cmos_dvp_tx #(
        .H_ACT     (4),
        .H_BLANK   (6),
        .V_ACT     (3),
        .VSYNC_LEN (1),
        .V_BP      (1),
        .V_FP      (1)
    ) dut (
        .cam_pclk   (cam_pclk),
        .rst_n      (rst_n),
        .tx_en      (tx_en),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .frame_done (frame_done),
        .underrun   (underrun),
        .frame_cnt  (frame_cnt)
    );

    always #5 cam_pclk = ~cam_pclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        tx_en     = 1'b0;
        pix_valid = 1'b0;
        pix_data  = 24'h0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Leaves the bench at c=0: first cycle in VSYNC.
    task automatic start_frame();
        do_reset();
        tx_en     = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 24'hFF8040;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tx_en = 1'b1; pix_valid = 1'b1; pix_data = 24'hFFFFFF;
        tick();
        tick();
        checks++; if (cam_vsync !== 1'b0) $display("FAIL reset_vsync: got %b want 0", cam_vsync); else passed++;
        checks++; if (cam_href !== 1'b0) $display("FAIL reset_href: got %b want 0", cam_href); else passed++;
        checks++; if (cam_data !== 8'h00) $display("FAIL reset_data: got %h want 00", cam_data); else passed++;
        checks++; if (pix_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", pix_ready); else passed++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else passed++;
        checks++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passed++;
        // Disabled transmitter stays idle.
        rst_n = 1'b1; tx_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (cam_vsync !== 1'b0 || cam_href !== 1'b0 || pix_ready !== 1'b0)
                $display("FAIL idle_quiet: cycle %0d got vsync=%b href=%b ready=%b want 0/0/0",
                         c, cam_vsync, cam_href, pix_ready);
            else passed++;
        end
    endtask

    // Two back-to-back frames of 0xFF8040 (RGB565 bytes 0xFC, 0x08).
    task automatic test_frame_timing();
        int n_ready = 0;
        start_frame();
        for (int c = 0; c < 168; c++) begin
            int   f, d, d2;
            logic e_vs, e_hr, e_rdy, e_done;
            logic [7:0] e_dat;
            f  = c % 84;
            d  = f - 29;
            d2 = f - 28;
            e_vs   = (f >= 1) && (f <= 14);
            e_hr   = (d >= 0) && (d < 42) && ((d % 14) < 8);
            e_dat  = e_hr ? ((((d % 14) % 2) == 0) ? 8'hFC : 8'h08) : 8'h00;
            e_rdy  = (d2 >= 0) && (d2 < 42) && ((d2 % 14) < 8) && ((d2 % 2) == 0);
            e_done = (f == 83);
            if (c < 84 && pix_ready === 1'b1) n_ready++;
            checks++; if (cam_vsync !== e_vs) $display("FAIL vsync: cycle %0d got %b want %b", c, cam_vsync, e_vs); else passed++;
            checks++; if (cam_href !== e_hr) $display("FAIL href: cycle %0d got %b want %b", c, cam_href, e_hr); else passed++;
            checks++; if (cam_data !== e_dat) $display("FAIL data: cycle %0d got %h want %h", c, cam_data, e_dat); else passed++;
            checks++; if (pix_ready !== e_rdy) $display("FAIL ready: cycle %0d got %b want %b", c, pix_ready, e_rdy); else passed++;
            checks++; if (frame_done !== e_done) $display("FAIL frame_done: cycle %0d got %b want %b", c, frame_done, e_done); else passed++;
            if (c == 83) begin
                checks++; if (frame_cnt !== 16'd0) $display("FAIL frame_cnt_pre: got %0d want 0", frame_cnt); else passed++;
            end
            if (c == 84) begin
                checks++; if (frame_cnt !== 16'd1) $display("FAIL frame_cnt_1: got %0d want 1", frame_cnt); else passed++;
                checks++; if (n_ready !== 12) $display("FAIL ready_count: got %0d want 12", n_ready); else passed++;
            end
            tick();
        end
        checks++; if (frame_cnt !== 16'd2) $display("FAIL frame_cnt_2: got %0d want 2", frame_cnt); else passed++;
        checks++; if (underrun !== 1'b0) $display("FAIL no_underrun: got %b want 0", underrun); else passed++;
    endtask

    // Pixel 1 of active line 1 (ready at c=44) is missing.
    task automatic test_underrun();
        start_frame();
        for (int c = 0; c < 85; c++) begin
            pix_valid = (c != 44);
            pix_data  = (c == 46) ? 24'h123456 : 24'hFF8040;
            if (c == 44) begin
                checks++; if (pix_ready !== 1'b1) $display("FAIL ur_ready_no_valid: got %b want 1", pix_ready); else passed++;
                checks++; if (underrun !== 1'b0) $display("FAIL ur_before: got %b want 0", underrun); else passed++;
            end
            if (c == 45) begin
                checks++; if (cam_data !== 8'h00) $display("FAIL ur_hi_zero: got %h want 00", cam_data); else passed++;
                checks++; if (cam_href !== 1'b1) $display("FAIL ur_href: got %b want 1", cam_href); else passed++;
                checks++; if (underrun !== 1'b1) $display("FAIL ur_set: got %b want 1", underrun); else passed++;
            end
            if (c == 46) begin
                checks++; if (cam_data !== 8'h00) $display("FAIL ur_lo_zero: got %h want 00", cam_data); else passed++;
            end
            if (c == 47) begin
                checks++; if (cam_data !== 8'h11) $display("FAIL ur_next_hi: got %h want 11", cam_data); else passed++;
            end
            if (c == 48) begin
                checks++; if (cam_data !== 8'hAA) $display("FAIL ur_next_lo: got %h want aa", cam_data); else passed++;
            end
            if (c == 49) begin
                checks++; if (cam_data !== 8'hFC) $display("FAIL ur_after_hi: got %h want fc", cam_data); else passed++;
            end
            if (c == 84) begin
                checks++; if (underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", underrun); else passed++;
            end
            tick();
        end
    endtask

    // tx_en low from the 2nd active line; re-raised at c=88.
    task automatic test_tx_en_drop();
        start_frame();
        for (int c = 0; c < 92; c++) begin
            tx_en = !((c >= 42) && (c < 88));
            if (c == 83) begin
                checks++; if (frame_done !== 1'b1) $display("FAIL txd_done: got %b want 1", frame_done); else passed++;
            end
            if (c == 84) begin
                checks++; if (frame_cnt !== 16'd1) $display("FAIL txd_frame_cnt: got %0d want 1", frame_cnt); else passed++;
            end
            if (c >= 85 && c <= 89) begin
                checks++; if (cam_vsync !== 1'b0) $display("FAIL txd_vsync_idle: cycle %0d got %b want 0", c, cam_vsync); else passed++;
            end
            if (c >= 84 && c <= 90) begin
                checks++; if (cam_href !== 1'b0) $display("FAIL txd_href_idle: cycle %0d got %b want 0", c, cam_href); else passed++;
            end
            if (c == 86) begin
                checks++; if (pix_ready !== 1'b0) $display("FAIL txd_ready_idle: got %b want 0", pix_ready); else passed++;
            end
            if (c == 90) begin
                checks++; if (cam_vsync !== 1'b1) $display("FAIL txd_restart: got %b want 1", cam_vsync); else passed++;
            end
            tick();
        end
    endtask

    // Reset pulse mid-ACTIVE of the second frame (c=114).
    task automatic test_reset_mid();
        start_frame();
        for (int c = 0; c < 119; c++) begin
            pix_valid = (c != 112);
            rst_n     = (c != 114);
            if (c == 113) begin
                checks++; if (underrun !== 1'b1) $display("FAIL rm_underrun_set: got %b want 1", underrun); else passed++;
            end
            if (c == 114) begin
                checks++; if (frame_cnt !== 16'd1) $display("FAIL rm_cnt_before: got %0d want 1", frame_cnt); else passed++;
                checks++; if (cam_href !== 1'b1) $display("FAIL rm_href_before: got %b want 1", cam_href); else passed++;
            end
            if (c == 115) begin
                checks++; if (cam_vsync !== 1'b0) $display("FAIL rm_vsync: got %b want 0", cam_vsync); else passed++;
                checks++; if (cam_href !== 1'b0) $display("FAIL rm_href: got %b want 0", cam_href); else passed++;
                checks++; if (cam_data !== 8'h00) $display("FAIL rm_data: got %h want 00", cam_data); else passed++;
                checks++; if (pix_ready !== 1'b0) $display("FAIL rm_ready: got %b want 0", pix_ready); else passed++;
                checks++; if (frame_done !== 1'b0) $display("FAIL rm_done: got %b want 0", frame_done); else passed++;
                checks++; if (underrun !== 1'b0) $display("FAIL rm_underrun: got %b want 0", underrun); else passed++;
                checks++; if (frame_cnt !== 16'd0) $display("FAIL rm_frame_cnt: got %0d want 0", frame_cnt); else passed++;
            end
            if (c == 116) begin
                checks++; if (cam_vsync !== 1'b0) $display("FAIL rm_vsync_entry: got %b want 0", cam_vsync); else passed++;
            end
            if (c == 117) begin
                checks++; if (cam_vsync !== 1'b1) $display("FAIL rm_fresh_vsync: got %b want 1", cam_vsync); else passed++;
                checks++; if (frame_cnt !== 16'd0) $display("FAIL rm_fresh_cnt: got %0d want 0", frame_cnt); else passed++;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; tx_en = 1'b0; pix_valid = 1'b0; pix_data = 24'h0;
        test_reset();
        test_frame_timing();
        test_underrun();
        test_tx_en_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
